fp8_operand_loader: RTL and testbench
=====================================

# fp8_operand_loader

Upstream operand stage for the FP8 (E4M3) multiplier. It receives operand bytes one at a time over the 8-bit dedicated input bus and pairs them as A then B. Each operand is unpacked into sign, effective exponent and significand, and classified. The registered pair is presented to the multiplier over a valid/ready handshake, and one staged A operand can be accepted while the current pair is still held.

## Interface
Parameters:
- EXP_W, 4, exponent width; EXP_W+MAN_W must equal 7
- MAN_W, 3, stored mantissa width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  8  operand byte {sign, exp[EXP_W-1:0], man[MAN_W-1:0]}
- in_valid  in  1  byte present
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_flush  in  1  discard a half-loaded (staged A) operand
- out_valid  out  1  operand pair valid
- out_ready  in  1  multiplier accepts pair
- out_a_sign, out_b_sign  out  1  operand signs
- out_a_exp, out_b_exp  out  EXP_W  effective biased exponent
- out_a_sig, out_b_sig  out  MAN_W+1  significand including hidden bit
- out_a_cls, out_b_cls  out  2  class (ZERO, SUB, NORM, NAN)
- out_nan_any  out  1  either operand is NaN
- pair_cnt  out  8  count of pairs handed off; wraps

## Operation
States are EMPTY, GOT_A, PAIR and PAIR_GOT_A.
- EMPTY: an accepted byte is stored as staged A and the block moves to GOT_A.
- GOT_A: an accepted byte becomes B. Staged A and B are unpacked and registered to the outputs, and the block moves to PAIR.
- PAIR: out_valid=1.
  - A handshake alone moves to EMPTY.
  - An accepted byte alone is stored as staged A and the block moves to PAIR_GOT_A.
  - A handshake and an accepted byte in the same cycle move to GOT_A.
- PAIR_GOT_A: in_ready=0. A handshake moves to GOT_A; the staged A is retained.
- in_ready = !rst && !in_flush && (state != PAIR_GOT_A).
- in_flush:
  - GOT_A goes to EMPTY.
  - PAIR_GOT_A goes to PAIR. If a handshake occurs in the same cycle, it goes to EMPTY.
  - EMPTY and PAIR are unaffected.
  - The held output pair is never dropped by in_flush.
- Unpack rules for E4M3, bias 7:
  - exp=0 and man=0: ZERO, exp_out 0, sig 0.
  - exp=0 and man!=0: SUB, exp_out 1, sig {0,man}.
  - exp=all-ones and man=all-ones: NAN, exp_out all-ones, sig {1,man}.
  - Otherwise: NORM, exp_out exp, sig {1,man}.
  - The sign always passes through unchanged.
- pair_cnt increments by 1 on each out_valid && out_ready and wraps from 255 to 0.
- Output pair fields are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - State is EMPTY.
  - out_valid, out_nan_any and pair_cnt are 0.
  - All out_a/out_b fields are 0.
  - Staged A is 0.
  - in_ready is 0 while rst=1 and 1 in the first cycle after reset.
- Latency: a B byte accepted at edge N gives out_valid=1 with the pair fields from edge N onward.
- Throughput: one pair every 2 cycles, provided out_ready is held high.
- No combinational path exists from out_ready to in_ready.
- Reset asserted mid-operation returns the block to the reset values at the next edge. Any staged A and held pair are lost.

## Configuration
- FP8_LOADER_FTZ_EN defined:
  - Subnormal inputs are flushed: class ZERO, exp_out 0, sig 0, sign preserved.
  - Class SUB is never produced.
- FP8_LOADER_FTZ_EN undefined: subnormals are unpacked as SUB, as described under Operation.

## Structure
- Package fp8_pkg:
  - Class enum cls_t: CLS_ZERO=2'b00, CLS_SUB=2'b01, CLS_NORM=2'b10, CLS_NAN=2'b11.
  - Loader state enum.
  - Constants for EXP_W, MAN_W and bias 7.
- Sub-module fp8_unpack: combinational unpack and classify of one byte, honours FP8_LOADER_FTZ_EN.
- fp8_unpack is instantiated twice: once on staged A, once on the incoming B byte.
- The top level holds the FSM, staged A register, output registers and pair_cnt.

## Test plan
- Basic pair: reset, send A=0x38 then B=0xC0, out_ready=1.
  - out_valid rises one cycle after B is accepted.
  - A fields: sign 0, exp 7, sig 4'b1000, NORM.
  - B fields: sign 1, exp 8, sig 4'b1000, NORM.
  - pair_cnt goes from 0 to 1 after the handshake.
- Backpressure: out_ready=0, send 0x38, 0x40, 0x48, then offer 0x50.
  - State reaches PAIR_GOT_A and in_ready=0.
  - The pair (0x38, 0x40) stays stable.
  - After out_ready pulses, 0x50 is accepted and the pair (0x48, 0x50) appears.
- Specials: A=0x7F, B=0x80.
  - A is NAN with sig 4'b1111.
  - B is ZERO with sign 1.
  - out_nan_any=1.
- Subnormal: A=0x01, B=0x08.
  - Without FTZ: A is SUB, exp 1, sig 4'b0001; B is NORM, exp 1, sig 4'b1000.
  - With FP8_LOADER_FTZ_EN: A is ZERO with sig 0.
- Flush and simultaneous events:
  - Flush in GOT_A: the next byte becomes A.
  - Flush in PAIR_GOT_A together with a handshake: the block goes to EMPTY.
  - in_flush together with in_valid: the byte is not accepted.
- Wrap and reset: 256 handshakes return pair_cnt to 0. Asserting rst while in PAIR_GOT_A returns all outputs to 0 at the next edge.

Source files
------------

// File: rtl/fp8_pkg.sv
// Shared types and constants for the FP8 (E4M3) operand loader.
// Build option: FP8_LOADER_FTZ_EN flushes subnormal operands to zero.
package fp8_pkg;
  localparam int FP8_EXP_W = 4;
  localparam int FP8_MAN_W = 3;
  localparam int FP8_BIAS  = 7;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'b00,
    CLS_SUB  = 2'b01,
    CLS_NORM = 2'b10,
    CLS_NAN  = 2'b11
  } cls_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_GOT_A,
    ST_PAIR,
    ST_PAIR_GOT_A
  } ld_state_t;
endpackage

// File: rtl/fp8_unpack.sv
// Combinational unpack/classify of one E4M3 byte into sign, effective exponent, significand.
// Build option: FP8_LOADER_FTZ_EN turns subnormals into signed zeros.
module fp8_unpack import fp8_pkg::*; #(
  parameter int EXP_W = FP8_EXP_W,
  parameter int MAN_W = FP8_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] i_byte,
  output logic                 o_sign,
  output logic [EXP_W-1:0]     o_exp,
  output logic [MAN_W:0]       o_sig,
  output logic [1:0]           o_cls
);
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_exp  = i_byte[MAN_W +: EXP_W];
  assign w_man  = i_byte[MAN_W-1:0];
  assign o_sign = i_byte[EXP_W+MAN_W];

  always_comb begin
    o_cls = CLS_NORM;
    o_exp = w_exp;
    o_sig = {1'b1, w_man};
    if (w_exp == '0) begin
      if (w_man == '0) begin
        o_cls = CLS_ZERO;
        o_exp = '0;
        o_sig = '0;
      end else begin
`ifdef FP8_LOADER_FTZ_EN
        o_cls = CLS_ZERO;
        o_exp = '0;
        o_sig = '0;
`else
        // Subnormals share the exponent of the smallest normal; hidden bit is 0.
        o_cls = CLS_SUB;
        o_exp = EXP_W'(1);
        o_sig = {1'b0, w_man};
`endif
      end
    end else if ((&w_exp) && (&w_man)) begin
      o_cls = CLS_NAN;
    end
  end
endmodule

// File: rtl/fp8_operand_loader.sv
// Pairs incoming operand bytes (A then B), unpacks them and holds the pair for the multiplier.
// Build option: FP8_LOADER_FTZ_EN (handled in fp8_unpack).
module fp8_operand_loader import fp8_pkg::*; #(
  parameter int EXP_W = FP8_EXP_W,
  parameter int MAN_W = FP8_MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a_sign,
  output logic             out_b_sign,
  output logic [EXP_W-1:0] out_a_exp,
  output logic [EXP_W-1:0] out_b_exp,
  output logic [MAN_W:0]   out_a_sig,
  output logic [MAN_W:0]   out_b_sig,
  output logic [1:0]       out_a_cls,
  output logic [1:0]       out_b_cls,
  output logic             out_nan_any,
  output logic [7:0]       pair_cnt
);
  if (EXP_W + MAN_W != 7) begin : g_bad_width
    $error("fp8_operand_loader: EXP_W+MAN_W must equal 7");
  end

  ld_state_t        r_state, w_nxt;
  logic [7:0]       r_a;
  logic             r_a_sign, r_b_sign, r_nan_any;
  logic [EXP_W-1:0] r_a_exp, r_b_exp;
  logic [MAN_W:0]   r_a_sig, r_b_sig;
  logic [1:0]       r_a_cls, r_b_cls;
  logic [7:0]       r_pair_cnt;

  logic             w_acc, w_hs, w_ld_a, w_ld_pair;
  logic             w_a_sign, w_b_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W:0]   w_a_sig, w_b_sig;
  logic [1:0]       w_a_cls, w_b_cls;

  fp8_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unp_a (
    .i_byte(r_a), .o_sign(w_a_sign), .o_exp(w_a_exp), .o_sig(w_a_sig), .o_cls(w_a_cls));
  fp8_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unp_b (
    .i_byte(in_data), .o_sign(w_b_sign), .o_exp(w_b_exp), .o_sig(w_b_sig), .o_cls(w_b_cls));

  // in_ready depends only on state and inputs other than out_ready.
  assign in_ready  = !rst && !in_flush && (r_state != ST_PAIR_GOT_A);
  assign out_valid = (r_state == ST_PAIR) || (r_state == ST_PAIR_GOT_A);
  assign w_acc     = in_valid && in_ready;
  assign w_hs      = out_valid && out_ready;
  assign w_ld_a    = w_acc && ((r_state == ST_EMPTY) || (r_state == ST_PAIR));
  assign w_ld_pair = w_acc && (r_state == ST_GOT_A);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_acc) w_nxt = ST_GOT_A;
      ST_GOT_A: begin
        if (in_flush)   w_nxt = ST_EMPTY;
        else if (w_acc) w_nxt = ST_PAIR;
      end
      ST_PAIR: begin
        if (w_hs && w_acc) w_nxt = ST_GOT_A;
        else if (w_hs)     w_nxt = ST_EMPTY;
        else if (w_acc)    w_nxt = ST_PAIR_GOT_A;
      end
      ST_PAIR_GOT_A: begin
        if (in_flush) w_nxt = w_hs ? ST_EMPTY : ST_PAIR;
        else if (w_hs) w_nxt = ST_GOT_A;
      end
      default: w_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_a        <= '0;
      r_a_sign   <= 1'b0;
      r_a_exp    <= '0;
      r_a_sig    <= '0;
      r_a_cls    <= CLS_ZERO;
      r_b_sign   <= 1'b0;
      r_b_exp    <= '0;
      r_b_sig    <= '0;
      r_b_cls    <= CLS_ZERO;
      r_nan_any  <= 1'b0;
      r_pair_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_ld_a) r_a <= in_data;
      if (w_ld_pair) begin
        r_a_sign  <= w_a_sign;
        r_a_exp   <= w_a_exp;
        r_a_sig   <= w_a_sig;
        r_a_cls   <= w_a_cls;
        r_b_sign  <= w_b_sign;
        r_b_exp   <= w_b_exp;
        r_b_sig   <= w_b_sig;
        r_b_cls   <= w_b_cls;
        r_nan_any <= (w_a_cls == CLS_NAN) || (w_b_cls == CLS_NAN);
      end
      if (w_hs) r_pair_cnt <= r_pair_cnt + 8'd1;
    end
  end

  assign out_a_sign  = r_a_sign;
  assign out_a_exp   = r_a_exp;
  assign out_a_sig   = r_a_sig;
  assign out_a_cls   = r_a_cls;
  assign out_b_sign  = r_b_sign;
  assign out_b_exp   = r_b_exp;
  assign out_b_sig   = r_b_sig;
  assign out_b_cls   = r_b_cls;
  assign out_nan_any = r_nan_any;
  assign pair_cnt    = r_pair_cnt;
endmodule

// File: tb/tb_fp8_operand_loader.sv
// Directed bench for fp8_operand_loader with hand-computed unpacked operand fields.
module tb_fp8_operand_loader;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_flush, out_ready, in_ready, out_valid;
  logic [7:0] in_data, pair_cnt;
  logic       out_a_sign, out_b_sign, out_nan_any;
  logic [3:0] out_a_exp, out_b_exp, out_a_sig, out_b_sig;
  logic [1:0] out_a_cls, out_b_cls;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp8_operand_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_flush(in_flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a_sign(out_a_sign), .out_b_sign(out_b_sign), .out_a_exp(out_a_exp), .out_b_exp(out_b_exp),
    .out_a_sig(out_a_sig), .out_b_sig(out_b_sig), .out_a_cls(out_a_cls), .out_b_cls(out_b_cls),
    .out_nan_any(out_nan_any), .pair_cnt(pair_cnt));

  // {sign, exp, sig, cls}
  function automatic logic [10:0] pk(input logic s, input logic [3:0] e, input logic [3:0] g,
                                     input logic [1:0] c);
    return {s, e, g, c};
  endfunction

  function automatic logic [10:0] fa();
    return {out_a_sign, out_a_exp, out_a_sig, out_a_cls};
  endfunction

  function automatic logic [10:0] fb();
    return {out_b_sign, out_b_exp, out_b_sig, out_b_cls};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic hs();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  localparam logic [10:0] F38 = {1'b0, 4'd7,  4'b1000, 2'b10};
  localparam logic [10:0] FC0 = {1'b1, 4'd8,  4'b1000, 2'b10};
  localparam logic [10:0] F40 = {1'b0, 4'd8,  4'b1000, 2'b10};
  localparam logic [10:0] F48 = {1'b0, 4'd9,  4'b1000, 2'b10};
  localparam logic [10:0] F50 = {1'b0, 4'd10, 4'b1000, 2'b10};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    step(); step();
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_cnt", 16'(pair_cnt), 16'd0);
    chk("rst_a", 16'(fa()), 16'd0);
    chk("rst_b", 16'(fb()), 16'd0);
    chk("rst_nan", 16'(out_nan_any), 16'd0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", 16'(in_ready), 16'd1);

    // basic pair
    send(8'h38);
    chk("basic_no_valid", 16'(out_valid), 16'd0);
    send(8'hC0);
    chk("basic_valid", 16'(out_valid), 16'd1);
    chk("basic_a", 16'(fa()), 16'(pk(1'b0, 4'd7, 4'b1000, 2'b10)));
    chk("basic_b", 16'(fb()), 16'(pk(1'b1, 4'd8, 4'b1000, 2'b10)));
    chk("basic_nan", 16'(out_nan_any), 16'd0);
    chk("basic_cnt0", 16'(pair_cnt), 16'd0);
    hs();
    chk("basic_cnt1", 16'(pair_cnt), 16'd1);
    chk("basic_drained", 16'(out_valid), 16'd0);

    // backpressure
    send(8'h38); send(8'h40); send(8'h48);
    chk("bp_in_ready", 16'(in_ready), 16'd0);
    chk("bp_valid", 16'(out_valid), 16'd1);
    in_valid = 1'b1; in_data = 8'h50;
    step();
    chk("bp_hold_a", 16'(fa()), 16'(F38));
    chk("bp_hold_b", 16'(fb()), 16'(F40));
    chk("bp_hold_rdy", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_after_hs_valid", 16'(out_valid), 16'd0);
    chk("bp_after_hs_rdy", 16'(in_ready), 16'd1);
    chk("bp_cnt2", 16'(pair_cnt), 16'd2);
    step();
    in_valid = 1'b0;
    chk("bp_pair2_valid", 16'(out_valid), 16'd1);
    chk("bp_pair2_a", 16'(fa()), 16'(F48));
    chk("bp_pair2_b", 16'(fb()), 16'(F50));
    hs();
    chk("bp_cnt3", 16'(pair_cnt), 16'd3);

    // specials
    send(8'h7F); send(8'h80);
    chk("sp_a_nan", 16'(fa()), 16'(pk(1'b0, 4'hF, 4'b1111, 2'b11)));
    chk("sp_b_negzero", 16'(fb()), 16'(pk(1'b1, 4'd0, 4'd0, 2'b00)));
    chk("sp_nan_any", 16'(out_nan_any), 16'd1);
    hs();

    // subnormal
    send(8'h01); send(8'h08);
`ifdef FP8_LOADER_FTZ_EN
    chk("sub_a_ftz", 16'(fa()), 16'(pk(1'b0, 4'd0, 4'd0, 2'b00)));
`else
    chk("sub_a", 16'(fa()), 16'(pk(1'b0, 4'd1, 4'b0001, 2'b01)));
`endif
    chk("sub_b", 16'(fb()), 16'(pk(1'b0, 4'd1, 4'b1000, 2'b10)));
    chk("sub_nan_any", 16'(out_nan_any), 16'd0);
    hs();
    chk("cnt5", 16'(pair_cnt), 16'd5);

    // flush in GOT_A with a byte offered
    send(8'h40);
    in_flush = 1'b1; in_valid = 1'b1; in_data = 8'h48; #1;
    chk("flush_rdy", 16'(in_ready), 16'd0);
    step();
    in_flush = 1'b0; in_valid = 1'b0;
    chk("flush_no_pair", 16'(out_valid), 16'd0);
    send(8'h38); send(8'hC0);
    chk("flush_newA", 16'(fa()), 16'(F38));
    chk("flush_newB", 16'(fb()), 16'(FC0));

    // flush in PAIR_GOT_A alone -> PAIR, pair kept
    send(8'h48);
    in_flush = 1'b1;
    step();
    in_flush = 1'b0; #1;
    chk("pga_flush_rdy", 16'(in_ready), 16'd1);
    chk("pga_flush_valid", 16'(out_valid), 16'd1);
    chk("pga_flush_a", 16'(fa()), 16'(F38));
    hs();
    chk("cnt6", 16'(pair_cnt), 16'd6);

    // flush in PAIR_GOT_A together with handshake -> EMPTY
    send(8'h38); send(8'h40); send(8'h48);
    in_flush = 1'b1; out_ready = 1'b1;
    step();
    in_flush = 1'b0; out_ready = 1'b0;
    chk("pga_fhs_valid", 16'(out_valid), 16'd0);
    chk("cnt7", 16'(pair_cnt), 16'd7);
    send(8'h50);
    chk("pga_fhs_empty", 16'(out_valid), 16'd0);
    send(8'h58);
    chk("pga_fhs_a", 16'(fa()), 16'(F50));
    chk("pga_fhs_b", 16'(fb()), 16'(pk(1'b0, 4'd11, 4'b1000, 2'b10)));
    hs();

    // streaming with out_ready high: one pair per two cycles
    out_ready = 1'b1;
    send(8'h38); send(8'h40); send(8'h48); send(8'h50);
    chk("stream_valid", 16'(out_valid), 16'd1);
    chk("stream_a", 16'(fa()), 16'(F48));
    chk("stream_cnt", 16'(pair_cnt), 16'd9);
    step();
    out_ready = 1'b0;
    chk("stream_cnt2", 16'(pair_cnt), 16'd10);

    // wrap
    for (int i = 0; i < 245; i++) begin
      send(8'h38); send(8'h40); hs();
    end
    chk("cnt255", 16'(pair_cnt), 16'd255);
    send(8'h38); send(8'h40); hs();
    chk("cnt_wrap", 16'(pair_cnt), 16'd0);

    // reset while in PAIR_GOT_A
    send(8'h7F); send(8'h80); send(8'h38);
    chk("pre_rst_rdy", 16'(in_ready), 16'd0);
    hs(); send(8'h40); send(8'h48);
    chk("pre_rst_cnt", 16'(pair_cnt), 16'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_a", 16'(fa()), 16'd0);
    chk("mid_rst_b", 16'(fb()), 16'd0);
    chk("mid_rst_cnt", 16'(pair_cnt), 16'd0);
    chk("mid_rst_rdy", 16'(in_ready), 16'd0);
    rst = 1'b0; #1;
    chk("mid_rst_rdy_after", 16'(in_ready), 16'd1);
    send(8'h40);
    chk("mid_rst_stageA_lost", 16'(out_valid), 16'd0);
    send(8'h50);
    chk("mid_rst_newA", 16'(fa()), 16'(F40));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
